// File: rtl/router_fifo_pkg.sv
// Shared constants and Gray-code helpers for the router FIFOs.
package router_fifo_pkg;

    localparam int unsigned DEF_DATA_WIDTH  = 8;
    localparam int unsigned DEF_ADDR_WIDTH  = 5;
    localparam int unsigned DEF_SYNC_STAGES = 2;

    // Helpers work on a fixed wide vector; callers cast to their pointer width.
    localparam int unsigned PTR_MAX_W = 32;

    // Binary to reflected Gray code.
    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Reflected Gray code back to binary (prefix XOR from the MSB down).
    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
        logic [PTR_MAX_W-1:0] b;
        b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
        for (int i = int'(PTR_MAX_W) - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_sync.sv
// Multi-flop synchroniser for Gray-coded pointers (or single control bits).
module gray_sync #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [STAGES];

    // Shift chain; stage 0 is the metastability-catching flop.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d;
            for (int i = 1; i < int'(STAGES); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/async_fifo_param.sv
// Parametrised dual-clock FIFO carrying router packet bytes from wr_clk to rd_clk.
module async_fifo_param
    import router_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int unsigned AF_LEVEL    = 28,
    parameter int unsigned AE_LEVEL    = 4,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned FWFT        = 0
) (
    input  logic                  wr_clk,
    input  logic                  rd_clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_full,
    output logic                  wr_almost_full,
    output logic [ADDR_WIDTH:0]   wr_level,
    output logic                  wr_overflow,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_empty,
    output logic                  rd_almost_empty,
    output logic [ADDR_WIDTH:0]   rd_level,
    output logic                  rd_underflow
);

    localparam int unsigned PW    = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    typedef logic [PW-1:0] ptr_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // ---------------- write domain ----------------
    ptr_t wr_bin, wr_gray;
    ptr_t rd_gray_ws, rd_bin_ws;
    ptr_t wr_bin_nxt, wr_gray_nxt, wr_level_nxt, rd_gray_full;
    logic wr_push;

    // Read pointer into the write domain.
    gray_sync #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_rptr_sync (
        .clk   (wr_clk),
        .reset (reset),
        .d     (rd_gray),
        .q     (rd_gray_ws)
    );

    // Next write pointer, full compare target and conservative level.
    always_comb begin
        wr_push      = wr_en & ~wr_full;
        wr_bin_nxt   = wr_bin + PW'(wr_push);
        wr_gray_nxt  = PW'(bin2gray(PTR_MAX_W'(wr_bin_nxt)));
        rd_bin_ws    = PW'(gray2bin(PTR_MAX_W'(rd_gray_ws)));
        wr_level_nxt = wr_bin_nxt - rd_bin_ws;
        rd_gray_full = rd_gray_ws ^ (ptr_t'(3) << (PW - 2));
    end

    // Storage write port; contents are deliberately not reset.
    always_ff @(posedge wr_clk) begin
        if (wr_push) begin
            mem[wr_bin[ADDR_WIDTH-1:0]] <= wr_data;
        end
    end

    // Write pointer, full flag, level and sticky overflow.
    always_ff @(posedge wr_clk) begin
        if (!reset) begin
            wr_bin         <= '0;
            wr_gray        <= '0;
            wr_full        <= 1'b0;
            wr_almost_full <= 1'b0;
            wr_level       <= '0;
            wr_overflow    <= 1'b0;
        end else begin
            wr_bin         <= wr_bin_nxt;
            wr_gray        <= wr_gray_nxt;
            wr_full        <= (wr_gray_nxt == rd_gray_full);
            wr_level       <= wr_level_nxt;
            wr_almost_full <= (wr_level_nxt >= PW'(AF_LEVEL));
            if (wr_en && wr_full) begin
                wr_overflow <= 1'b1;
            end
        end
    end

    // ---------------- read domain ----------------
    logic rd_reset;
    ptr_t rd_bin, rd_gray;
    ptr_t wr_gray_rs, wr_bin_rs;
    ptr_t rd_bin_nxt, rd_gray_nxt, rd_level_nxt;
    logic fifo_empty, fifo_empty_nxt;
    logic rd_valid, rd_valid_nxt;
    logic rd_pop, rd_empty_nxt;

    // Reset is sampled on wr_clk; the read domain sees a synchronised copy.
    gray_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_rst_sync (
        .clk   (rd_clk),
        .reset (1'b1),
        .d     (reset),
        .q     (rd_reset)
    );

    // Write pointer into the read domain.
    gray_sync #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_wptr_sync (
        .clk   (rd_clk),
        .reset (rd_reset),
        .d     (wr_gray),
        .q     (wr_gray_rs)
    );

    // Pop decision: direct read in standard mode, prefetch refill in FWFT mode.
    always_comb begin
        if (FWFT != 0) begin
            rd_pop       = ~fifo_empty & (~rd_valid | rd_en);
            rd_valid_nxt = rd_pop | (rd_valid & ~rd_en);
            rd_empty_nxt = ~rd_valid_nxt;
        end else begin
            rd_pop       = rd_en & ~fifo_empty;
            rd_valid_nxt = 1'b0;
            rd_empty_nxt = 1'b0;
        end
        rd_bin_nxt     = rd_bin + PW'(rd_pop);
        rd_gray_nxt    = PW'(bin2gray(PTR_MAX_W'(rd_bin_nxt)));
        wr_bin_rs      = PW'(gray2bin(PTR_MAX_W'(wr_gray_rs)));
        fifo_empty_nxt = (rd_gray_nxt == wr_gray_rs);
        if (FWFT == 0) begin
            rd_empty_nxt = fifo_empty_nxt;
        end
        // The prefetched word still counts as occupancy seen by the reader.
        rd_level_nxt   = wr_bin_rs - rd_bin_nxt + PW'(rd_valid_nxt);
    end

    // Read pointer, empty/valid state, output word, level and sticky underflow.
    always_ff @(posedge rd_clk) begin
        if (!rd_reset) begin
            rd_bin          <= '0;
            rd_gray         <= '0;
            fifo_empty      <= 1'b1;
            rd_valid        <= 1'b0;
            rd_empty        <= 1'b1;
            rd_almost_empty <= 1'b1;
            rd_level        <= '0;
            rd_underflow    <= 1'b0;
            rd_data         <= '0;
        end else begin
            rd_bin          <= rd_bin_nxt;
            rd_gray         <= rd_gray_nxt;
            fifo_empty      <= fifo_empty_nxt;
            rd_valid        <= rd_valid_nxt;
            rd_empty        <= rd_empty_nxt;
            rd_level        <= rd_level_nxt;
            rd_almost_empty <= (rd_level_nxt <= PW'(AE_LEVEL));
            if (rd_pop) begin
                rd_data <= mem[rd_bin[ADDR_WIDTH-1:0]];
            end
            if (rd_en && rd_empty) begin
                rd_underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_async_fifo_param.sv
// Directed bench for async_fifo_param: standard-mode and FWFT instances side by side.
`timescale 1ns/1ps
module tb_async_fifo_param;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 4;

    logic          wr_clk = 1'b0;
    logic          rd_clk = 1'b0;
    logic          reset;

    logic          wr_en, rd_en;
    logic [DW-1:0] wr_data, rd_data;
    logic          wr_full, wr_almost_full, wr_overflow;
    logic          rd_empty, rd_almost_empty, rd_underflow;
    logic [AW:0]   wr_level, rd_level;

    logic          f_wr_en, f_rd_en;
    logic [DW-1:0] f_wr_data, f_rd_data;
    logic          f_wr_full, f_wr_almost_full, f_wr_overflow;
    logic          f_rd_empty, f_rd_almost_empty, f_rd_underflow;
    logic [AW:0]   f_wr_level, f_rd_level;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] sbq [$];
    int            sent, got;
    logic [DW-1:0] last_rd;

    always #2 wr_clk = ~wr_clk;
    initial begin
        #0.5;
        forever #5 rd_clk = ~rd_clk;
    end

    async_fifo_param #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_LEVEL(12), .AE_LEVEL(4),
        .SYNC_STAGES(2), .FWFT(0)
    ) u_std (
        .wr_clk(wr_clk), .rd_clk(rd_clk), .reset(reset),
        .wr_en(wr_en), .wr_data(wr_data), .wr_full(wr_full),
        .wr_almost_full(wr_almost_full), .wr_level(wr_level), .wr_overflow(wr_overflow),
        .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty),
        .rd_almost_empty(rd_almost_empty), .rd_level(rd_level), .rd_underflow(rd_underflow)
    );

    async_fifo_param #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_LEVEL(12), .AE_LEVEL(4),
        .SYNC_STAGES(2), .FWFT(1)
    ) u_fwft (
        .wr_clk(wr_clk), .rd_clk(rd_clk), .reset(reset),
        .wr_en(f_wr_en), .wr_data(f_wr_data), .wr_full(f_wr_full),
        .wr_almost_full(f_wr_almost_full), .wr_level(f_wr_level), .wr_overflow(f_wr_overflow),
        .rd_en(f_rd_en), .rd_data(f_rd_data), .rd_empty(f_rd_empty),
        .rd_almost_empty(f_rd_almost_empty), .rd_level(f_rd_level), .rd_underflow(f_rd_underflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Hard time limit so the run always ends.
    initial begin
        #300us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0;
        f_wr_en = 1'b0; f_wr_data = '0; f_rd_en = 1'b0;
        sent = 0; got = 0; last_rd = '0;

        // Reset held for 10 rd_clk cycles.
        repeat (10) @(posedge rd_clk);
        @(posedge wr_clk); #1; reset = 1'b1;
        repeat (8) @(posedge rd_clk); #1;
        chk("rst_rd_empty", 32'(rd_empty), 32'd1);
        chk("rst_rd_ae", 32'(rd_almost_empty), 32'd1);
        chk("rst_wr_full", 32'(wr_full), 32'd0);
        chk("rst_wr_af", 32'(wr_almost_full), 32'd0);
        chk("rst_wr_level", 32'(wr_level), 32'd0);
        chk("rst_rd_level", 32'(rd_level), 32'd0);
        chk("rst_wr_ovf", 32'(wr_overflow), 32'd0);
        chk("rst_rd_udf", 32'(rd_underflow), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_f_rd_empty", 32'(f_rd_empty), 32'd1);
        chk("rst_f_rd_ae", 32'(f_rd_almost_empty), 32'd1);
        chk("rst_f_wr_full", 32'(f_wr_full), 32'd0);
        chk("rst_f_wr_af", 32'(f_wr_almost_full), 32'd0);
        chk("rst_f_wr_level", 32'(f_wr_level), 32'd0);
        chk("rst_f_ovf", 32'(f_wr_overflow), 32'd0);
        chk("rst_f_udf", 32'(f_rd_underflow), 32'd0);

        // Fill 0x00..0x0F back to back, no reads.
        @(posedge wr_clk); #1;
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            @(posedge wr_clk); #1;
            chk($sformatf("fill_level[%0d]", i), 32'(wr_level), 32'(i + 1));
            chk($sformatf("fill_full[%0d]", i), 32'(wr_full), 32'(i == 15));
            chk($sformatf("fill_af[%0d]", i), 32'(wr_almost_full), 32'(i + 1 >= 12));
        end

        // 17th write while full is dropped.
        wr_data = 8'hAA;
        @(posedge wr_clk); #1; wr_en = 1'b0;
        chk("ovf_flag", 32'(wr_overflow), 32'd1);
        chk("ovf_level", 32'(wr_level), 32'd16);
        chk("ovf_full", 32'(wr_full), 32'd1);

        repeat (6) @(posedge rd_clk); #1;
        chk("full_rd_level", 32'(rd_level), 32'd16);
        chk("full_rd_empty", 32'(rd_empty), 32'd0);
        chk("full_rd_ae", 32'(rd_almost_empty), 32'd0);

        // One pop, then count wr_clk edges until space is seen (3 edges).
        rd_en = 1'b1;
        @(posedge rd_clk);
        @(posedge wr_clk); #1; rd_en = 1'b0;
        chk("pop0_data", 32'(rd_data), 32'h00);
        chk("pop0_rd_level", 32'(rd_level), 32'd15);
        chk("free_edge1", 32'(wr_full), 32'd1);
        @(posedge wr_clk); #1;
        chk("free_edge2", 32'(wr_full), 32'd1);
        @(posedge wr_clk); #1;
        chk("free_edge3", 32'(wr_full), 32'd0);
        chk("free_wr_level", 32'(wr_level), 32'd15);
        chk("free_wr_af", 32'(wr_almost_full), 32'd1);

        // Drain the remaining 15 words.
        @(posedge rd_clk); #1;
        for (int i = 1; i < 16; i++) begin
            chk($sformatf("drain_nonempty[%0d]", i), 32'(rd_empty), 32'd0);
            rd_en = 1'b1;
            @(posedge rd_clk); #1;
            chk($sformatf("drain_data[%0d]", i), 32'(rd_data), 32'(i));
        end
        chk("drain_empty", 32'(rd_empty), 32'd1);
        chk("drain_rd_level", 32'(rd_level), 32'd0);
        chk("drain_rd_ae", 32'(rd_almost_empty), 32'd1);
        chk("drain_no_udf", 32'(rd_underflow), 32'd0);

        // rd_en still high on an empty FIFO.
        @(posedge rd_clk); #1; rd_en = 1'b0;
        chk("udf_flag", 32'(rd_underflow), 32'd1);
        chk("udf_data_hold", 32'(rd_data), 32'h0F);
        chk("udf_empty", 32'(rd_empty), 32'd1);
        repeat (4) @(posedge wr_clk); #1;
        chk("drained_wr_level", 32'(wr_level), 32'd0);
        chk("drained_wr_full", 32'(wr_full), 32'd0);
        chk("drained_wr_af", 32'(wr_almost_full), 32'd0);

        // Concurrent random traffic, 100 bytes, pointers wrap several times.
        fork
            begin : writer
                for (int c = 0; c < 4000 && sent < 100; c++) begin
                    @(posedge wr_clk); #1;
                    if (!wr_full && $urandom_range(0, 3) != 0) begin
                        wr_en = 1'b1;
                        wr_data = 8'($urandom);
                        sbq.push_back(wr_data);
                        sent++;
                    end else begin
                        wr_en = 1'b0;
                    end
                end
                @(posedge wr_clk); #1; wr_en = 1'b0;
            end
            begin : reader
                logic pend;
                logic [DW-1:0] exp_b;
                pend = 1'b0;
                for (int c = 0; c < 4000 && got < 100; c++) begin
                    @(posedge rd_clk); #1;
                    if (pend) begin
                        if (sbq.size() == 0) begin
                            chk("wrap_sb_underrun", 32'(sbq.size()), 32'd1);
                        end else begin
                            exp_b = sbq.pop_front();
                            chk($sformatf("wrap_data[%0d]", got), 32'(rd_data), 32'(exp_b));
                            last_rd = exp_b;
                        end
                        got++;
                    end
                    pend = 1'b0;
                    if (!rd_empty) begin
                        chk("wrap_nonempty_has_data", 32'(sbq.size() != 0), 32'd1);
                    end
                    if (!rd_empty && got < 100 && $urandom_range(0, 1) != 0) begin
                        rd_en = 1'b1;
                        pend = 1'b1;
                    end else begin
                        rd_en = 1'b0;
                    end
                end
                rd_en = 1'b0;
            end
        join
        chk("wrap_sent", 32'(sent), 32'd100);
        chk("wrap_got", 32'(got), 32'd100);
        repeat (6) @(posedge rd_clk); #1;
        chk("wrap_end_empty", 32'(rd_empty), 32'd1);
        chk("wrap_end_wr_level", 32'(wr_level), 32'd0);
        chk("wrap_ovf_sticky", 32'(wr_overflow), 32'd1);
        chk("wrap_udf_sticky", 32'(rd_underflow), 32'd1);

        // Write-to-visible latency: standard 3 rd edges, FWFT 4 rd edges.
        @(posedge wr_clk); #1;
        wr_en = 1'b1; wr_data = 8'h55; f_wr_en = 1'b1; f_wr_data = 8'h55;
        @(posedge wr_clk); #1;
        wr_en = 1'b0; f_wr_en = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge rd_clk); #1;
            if (k == 2) begin
                chk("vis_std_e2", 32'(rd_empty), 32'd1);
                chk("vis_fwft_e2", 32'(f_rd_empty), 32'd1);
            end
            if (k == 3) begin
                chk("vis_std_e3", 32'(rd_empty), 32'd0);
                chk("vis_fwft_e3", 32'(f_rd_empty), 32'd1);
            end
            if (k == 4) begin
                chk("vis_fwft_e4", 32'(f_rd_empty), 32'd0);
                chk("vis_fwft_data", 32'(f_rd_data), 32'h55);
                chk("vis_std_hold", 32'(rd_data), 32'(last_rd));
                chk("vis_fwft_level", 32'(f_rd_level), 32'd1);
            end
        end
        repeat (3) @(posedge rd_clk); #1;
        chk("fwft_hold_data", 32'(f_rd_data), 32'h55);
        chk("fwft_hold_valid", 32'(f_rd_empty), 32'd0);

        rd_en = 1'b1;
        @(posedge rd_clk); #1; rd_en = 1'b0;
        chk("std_read55", 32'(rd_data), 32'h55);
        chk("std_read55_empty", 32'(rd_empty), 32'd1);

        // FWFT acknowledge advances to the next word, then runs dry.
        @(posedge wr_clk); #1; f_wr_en = 1'b1; f_wr_data = 8'h66;
        @(posedge wr_clk); #1; f_wr_en = 1'b0;
        repeat (6) @(posedge rd_clk); #1;
        chk("fwft_head_still55", 32'(f_rd_data), 32'h55);
        f_rd_en = 1'b1;
        @(posedge rd_clk); #1; f_rd_en = 1'b0;
        chk("fwft_adv_data", 32'(f_rd_data), 32'h66);
        chk("fwft_adv_valid", 32'(f_rd_empty), 32'd0);
        f_rd_en = 1'b1;
        @(posedge rd_clk); #1; f_rd_en = 1'b0;
        chk("fwft_dry_empty", 32'(f_rd_empty), 32'd1);
        chk("fwft_dry_udf", 32'(f_rd_underflow), 32'd0);
        chk("fwft_dry_data", 32'(f_rd_data), 32'h66);

        // Almost-empty boundary: 4 queued -> asserted, 5 queued -> clear.
        @(posedge wr_clk); #1;
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h10 + i);
            f_wr_en = 1'b1; f_wr_data = 8'(8'h10 + i);
            @(posedge wr_clk); #1;
            wr_en = 1'b0; f_wr_en = 1'b0;
            if (i == 3) begin
                repeat (6) @(posedge rd_clk); #1;
                chk("ae4_std_level", 32'(rd_level), 32'd4);
                chk("ae4_std_ae", 32'(rd_almost_empty), 32'd1);
                chk("ae4_fwft_level", 32'(f_rd_level), 32'd4);
                chk("ae4_fwft_ae", 32'(f_rd_almost_empty), 32'd1);
                chk("ae4_fwft_head", 32'(f_rd_data), 32'h10);
                @(posedge wr_clk); #1;
            end
        end
        repeat (6) @(posedge rd_clk); #1;
        chk("ae5_std_level", 32'(rd_level), 32'd5);
        chk("ae5_std_ae", 32'(rd_almost_empty), 32'd0);
        chk("ae5_fwft_level", 32'(f_rd_level), 32'd5);
        chk("ae5_fwft_ae", 32'(f_rd_almost_empty), 32'd0);
        chk("ae5_std_wr_level", 32'(wr_level), 32'd5);

        // Mid-operation reset with 5 words queued.
        @(posedge wr_clk); #1; reset = 1'b0;
        repeat (10) @(posedge rd_clk);
        @(posedge wr_clk); #1; reset = 1'b1;
        repeat (6) @(posedge rd_clk); #1;
        chk("mrst_fwft_empty", 32'(f_rd_empty), 32'd1);
        chk("mrst_fwft_wr_level", 32'(f_wr_level), 32'd0);
        chk("mrst_fwft_rd_level", 32'(f_rd_level), 32'd0);
        chk("mrst_fwft_data", 32'(f_rd_data), 32'd0);
        chk("mrst_std_empty", 32'(rd_empty), 32'd1);
        chk("mrst_std_wr_level", 32'(wr_level), 32'd0);
        chk("mrst_std_ovf", 32'(wr_overflow), 32'd0);
        chk("mrst_std_udf", 32'(rd_underflow), 32'd0);
        chk("mrst_std_data", 32'(rd_data), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
